// File: rtl/ysyx_23060184_ifu_ctrl_pkg.sv
// Shared types and encodings for the instruction fetch controller.
// The next-PC select encoding matches the decode stage's pc_src field.
package ysyx_23060184_ifu_ctrl_pkg;

    localparam int PC_SRC_LENGTH = 2;

    localparam logic [PC_SRC_LENGTH-1:0] PC_SRC_PCPlus4 = 2'd0;
    localparam logic [PC_SRC_LENGTH-1:0] PC_SRC_PCTarget = 2'd1;
    localparam logic [PC_SRC_LENGTH-1:0] PC_SRC_ALU = 2'd2;
    localparam logic [PC_SRC_LENGTH-1:0] PC_SRC_CSRREAD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060184_ifu_nextpc.sv
// Redirect target mux: picks the new PC from the execute/CSR operands.
// PCPlus4 is sequential flow, so it does not count as a redirect.
module ysyx_23060184_ifu_nextpc
    import ysyx_23060184_ifu_ctrl_pkg::*;
(
    input  logic [PC_SRC_LENGTH-1:0] pc_src,
    input  logic [31:0]              pc_target,
    input  logic [31:0]              alu_result,
    input  logic [31:0]              csr_rdata,
    output logic                     redirect,
    output logic [31:0]              target
);

    always_comb begin
        redirect = 1'b1;
        target   = pc_target;
        case (pc_src)
            PC_SRC_PCTarget: target = pc_target;
            // JALR clears the low target bit
            PC_SRC_ALU:      target = {alu_result[31:1], 1'b0};
            PC_SRC_CSRREAD:  target = csr_rdata;
            default: begin
                redirect = 1'b0;
                target   = pc_target;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060184_ifu_ctrl.sv
// Instruction fetch controller: owns the PC, issues one imem fetch at a time
// and presents the fetched instruction until consumed or redirected.
//
// state | meaning
// IDLE  | one cycle after reset, before the first fetch
// REQ   | imem_req_valid high, waiting for imem_req_ready
// WAIT  | request accepted, waiting for imem_rsp_valid
// HOLD  | inst_valid high, waiting for inst_ready
module ysyx_23060184_ifu_ctrl
    import ysyx_23060184_ifu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [PC_SRC_LENGTH-1:0] pc_src,
    input  logic                     redirect_valid,
    input  logic [31:0]              pc_target,
    input  logic [31:0]              alu_result,
    input  logic [31:0]              csr_rdata,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [31:0]              imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [31:0]              inst,
    output logic [31:0]              inst_pc
);

    ifu_state_e  state;
    logic [31:0] pc;
    logic [31:0] pending_pc;
    logic        kill;
    logic        sel_redirect;
    logic [31:0] sel_target;
    logic        redirect;
    logic        req_fire;

    ysyx_23060184_ifu_nextpc u_nextpc (
        .pc_src     (pc_src),
        .pc_target  (pc_target),
        .alu_result (alu_result),
        .csr_rdata  (csr_rdata),
        .redirect   (sel_redirect),
        .target     (sel_target)
    );

    assign redirect      = redirect_valid & sel_redirect;
    assign req_fire      = imem_req_valid & imem_req_ready;
    assign imem_req_addr = pc;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            kill           <= 1'b0;
            pending_pc     <= 32'd0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= 32'd0;
            inst_pc        <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= 1'b1;
                end
                REQ: begin
                    if (req_fire) begin
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                        // fetch already in flight: its response must be dropped
                        if (redirect) begin
                            kill       <= 1'b1;
                            pending_pc <= sel_target;
                        end
                    end else if (redirect) begin
                        pc <= sel_target;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill || redirect) begin
                            pc             <= redirect ? sel_target : pending_pc;
                            kill           <= 1'b0;
                            state          <= REQ;
                            imem_req_valid <= 1'b1;
                        end else begin
                            inst       <= imem_rsp_data;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (redirect) begin
                        kill       <= 1'b1;
                        pending_pc <= sel_target;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        inst_valid     <= 1'b0;
                        pc             <= sel_target;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end else if (inst_ready) begin
                        inst_valid     <= 1'b0;
                        pc             <= pc + 32'd4;
                        state          <= REQ;
                        imem_req_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_ifu_ctrl.sv
// Directed bench for the fetch controller; expected instructions are queued
// when a response is driven and popped when inst_valid appears.
module tb_ysyx_23060184_ifu_ctrl;
    import ysyx_23060184_ifu_ctrl_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    logic                     clk;
    logic                     rstn;
    logic [PC_SRC_LENGTH-1:0] pc_src;
    logic                     redirect_valid;
    logic [31:0]              pc_target;
    logic [31:0]              alu_result;
    logic [31:0]              csr_rdata;
    logic                     imem_req_valid;
    logic                     imem_req_ready;
    logic [31:0]              imem_req_addr;
    logic                     imem_rsp_valid;
    logic [31:0]              imem_rsp_data;
    logic                     inst_valid;
    logic                     inst_ready;
    logic [31:0]              inst;
    logic [31:0]              inst_pc;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    ysyx_23060184_ifu_ctrl #(.RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .pc_src         (pc_src),
        .redirect_valid (redirect_valid),
        .pc_target      (pc_target),
        .alu_result     (alu_result),
        .csr_rdata      (csr_rdata),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_inst(input string tag);
        exp_t e;
        check({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_inst"}, inst, e.data);
            check({tag, "_pc"}, inst_pc, e.pc);
        end
    endtask

    // Called at a negedge with the DUT in REQ and imem_req_ready=1.
    task automatic fetch(input string tag, input logic [31:0] data, input logic [31:0] exp_pc);
        check({tag, "_addr"}, imem_req_addr, exp_pc);
        check({tag, "_req"}, {31'd0, imem_req_valid}, 32'd1);
        sb.push_back('{data: data, pc: exp_pc});
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        expect_inst(tag);
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    task automatic redir(input logic [PC_SRC_LENGTH-1:0] src, input logic [31:0] val);
        redirect_valid = 1'b1;
        pc_src         = src;
        pc_target      = val;
        alu_result     = val;
        csr_rdata      = val;
    endtask

    task automatic no_redir();
        redirect_valid = 1'b0;
        pc_src         = PC_SRC_PCPlus4;
    endtask

    initial begin
        int n;
        rstn           = 1'b0;
        pc_src         = PC_SRC_PCPlus4;
        redirect_valid = 1'b0;
        pc_target      = 32'd0;
        alu_result     = 32'd0;
        csr_rdata      = 32'd0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        inst_ready     = 1'b0;
        repeat (3) step();

        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);
        check("rst_addr", imem_req_addr, 32'h8000_0000);

        rstn = 1'b1;
        n = 0;
        for (int i = 0; i < 4 && !imem_req_valid; i++) begin
            step();
            n++;
        end
        check("first_req_latency", {31'd0, (n >= 1 && n <= 2)}, 32'd1);

        // basic fetch and consume
        fetch("f0", 32'h0000_0013, 32'h8000_0000);
        redir(PC_SRC_PCPlus4, 32'h1234_5670);
        step();
        no_redir();
        check("pcplus4_hold", {31'd0, inst_valid}, 32'd1);
        consume();
        check("f0_consumed", {31'd0, inst_valid}, 32'd0);
        check("f0_next_addr", imem_req_addr, 32'h8000_0004);

        // redirect while holding
        fetch("f1", 32'h0010_0093, 32'h8000_0004);
        redir(PC_SRC_PCTarget, 32'h8000_0100);
        step();
        no_redir();
        check("hold_redir_drop", {31'd0, inst_valid}, 32'd0);
        check("hold_redir_addr", imem_req_addr, 32'h8000_0100);
        check("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);

        // redirect during WAIT discards the response
        step();
        redir(PC_SRC_ALU, 32'h8000_0203);
        step();
        no_redir();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        check("wait_kill_no_inst", {31'd0, inst_valid}, 32'd0);
        check("wait_kill_addr", imem_req_addr, 32'h8000_0202);
        fetch("f2", 32'h0020_0113, 32'h8000_0202);
        consume();

        // redirect on the handshake cycle, then overridden in WAIT
        check("hs_pre_addr", imem_req_addr, 32'h8000_0206);
        redir(PC_SRC_PCTarget, 32'h8000_0500);
        step();
        redir(PC_SRC_CSRREAD, 32'h8000_0600);
        step();
        no_redir();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0001;
        step();
        imem_rsp_valid = 1'b0;
        check("last_wins_no_inst", {31'd0, inst_valid}, 32'd0);
        check("last_wins_addr", imem_req_addr, 32'h8000_0600);

        // stalled request, redirect in cycle 3
        imem_req_ready = 1'b0;
        step();
        check("stall_c1", imem_req_addr, 32'h8000_0600);
        step();
        check("stall_c2", imem_req_addr, 32'h8000_0600);
        redir(PC_SRC_CSRREAD, 32'h8000_0400);
        step();
        no_redir();
        check("stall_c3_redir", imem_req_addr, 32'h8000_0400);
        check("stall_c3_req", {31'd0, imem_req_valid}, 32'd1);
        step();
        check("stall_c4", imem_req_addr, 32'h8000_0400);
        step();
        check("stall_c5", imem_req_addr, 32'h8000_0400);
        imem_req_ready = 1'b1;
        fetch("f3", 32'h0030_0193, 32'h8000_0400);
        consume();

        // redirect and inst_ready together: redirect wins
        fetch("f4", 32'h0040_0213, 32'h8000_0404);
        redir(PC_SRC_PCTarget, 32'hFFFF_FFFC);
        inst_ready = 1'b1;
        step();
        no_redir();
        inst_ready = 1'b0;
        check("race_drop", {31'd0, inst_valid}, 32'd0);
        check("race_addr", imem_req_addr, 32'hFFFF_FFFC);
        fetch("f5", 32'h0050_0293, 32'hFFFF_FFFC);
        consume();
        check("wrap_addr", imem_req_addr, 32'h0000_0000);

        // reset mid-fetch, stale response afterwards
        step();
        check("mid_wait_req", {31'd0, imem_req_valid}, 32'd0);
        rstn = 1'b0;
        step();
        check("midrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("midrst_addr", imem_req_addr, 32'h8000_0000);
        rstn           = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0002;
        step();
        imem_rsp_valid = 1'b0;
        check("stale_no_inst", {31'd0, inst_valid}, 32'd0);
        check("stale_req", {31'd0, imem_req_valid}, 32'd1);
        fetch("f6", 32'h0060_0313, 32'h8000_0000);
        consume();

        check("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
